// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and helpers for the transmit arbiter.
// Holds the FSM state enum and the timeout counter width function.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_FINISH
  } state_e;

  // Counter must reach limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick over an eligible mask.
// Ports: eligible_i mask, last_i last grant; valid_o any hit, index_o pick.
module rr_select #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   index_o
);

  // Walk from the farthest candidate down to last+1 so the
  // nearest eligible index after last_i is the final writer.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    valid_o = 1'b0;
    index_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j  = (int'(last_i) + k) % NREQ;
      jj = IW'(j);
      if (eligible_i[jj]) begin
        valid_o = 1'b1;
        index_o = jj;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding one downstream word sender.
// Ports: req/req_word/req_bytes/enable in, ack/done/fault pulses out,
// tx_start/tx_word/tx_bytes to sender, tx_busy back, busy/owner status.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][31:0]    req_word,
  input  logic [NREQ-1:0][2:0]     req_bytes,
  input  logic [NREQ-1:0]          enable,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          done,
  output logic                     fault,
  output logic                     tx_start,
  output logic [31:0]              tx_word,
  output logic [2:0]               tx_bytes,
  input  logic                     tx_busy,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(BUSY_TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [31:0]     word_q, word_d;
  logic [2:0]      bytes_q, bytes_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            fault_q, fault_d;
  logic            flag_q, flag_d;
  logic            start_q, start_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;

  rr_select #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_rr (
    .eligible_i(req & enable),
    .last_i    (last_q),
    .valid_o   (sel_valid),
    .index_o   (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    word_d  = word_q;
    bytes_d = bytes_q;
    ack_d   = '0;
    done_d  = '0;
    fault_d = 1'b0;
    flag_d  = flag_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_idx;
          word_d  = req_word[sel_idx];
          bytes_d = req_bytes[sel_idx];
          ack_d   = NREQ'(1) << sel_idx;
          // Nothing to send: skip the sender handshake.
          if (req_bytes[sel_idx] == 3'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Sender response wins over a same-cycle timeout.
        if (tx_busy) begin
          start_d = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          start_d = 1'b0;
          flag_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = NREQ'(1) << owner_q;
        fault_d = flag_q;
        last_d  = owner_q;
        flag_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      word_q  <= '0;
      bytes_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      fault_q <= 1'b0;
      flag_q  <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      word_q  <= word_d;
      bytes_q <= bytes_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      flag_q  <= flag_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign tx_start = start_q;
  assign tx_word  = word_q;
  assign tx_bytes = bytes_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed plus randomized bench for tx_arbiter.
// A transfer-level model predicts every output each cycle.
module tb_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       req;
  logic [N-1:0][31:0] req_word;
  logic [N-1:0][2:0]  req_bytes;
  logic [N-1:0]       enable;
  logic [N-1:0]       ack;
  logic [N-1:0]       done;
  logic               fault;
  logic               tx_start;
  logic [31:0]        tx_word;
  logic [2:0]         tx_bytes;
  logic               tx_busy;
  logic               busy;
  logic [1:0]         owner;

  tx_arbiter #(
    .NREQ        (N),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_word (req_word),
    .req_bytes(req_bytes),
    .enable   (enable),
    .ack      (ack),
    .done     (done),
    .fault    (fault),
    .tx_start (tx_start),
    .tx_word  (tx_word),
    .tx_bytes (tx_bytes),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .owner    (owner)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Transfer-level model: a transfer is granted, acked next cycle,
  // start is raised one cycle later and held until the sender answers
  // or TO cycles pass, then a finishing cycle, then done/fault.
  bit           m_act  = 0;
  bit           m_fin  = 0;
  bit           m_sent = 0;
  bit           m_flag = 0;
  int           m_st   = 0;
  int           m_last = N - 1;
  logic [N-1:0] e_ack  = '0;
  logic [N-1:0] e_done = '0;
  logic         e_fault = 0;
  logic         e_start = 0;
  logic         e_busy  = 0;
  int           e_owner = 0;
  logic [31:0]  e_word  = '0;
  logic [2:0]   e_bytes = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_fin = 0; m_sent = 0; m_flag = 0; m_st = 0;
      m_last = N - 1;
      e_ack = '0; e_done = '0; e_fault = 0; e_start = 0;
      e_busy = 0; e_owner = 0; e_word = '0; e_bytes = '0;
    end else begin
      e_ack = '0; e_done = '0; e_fault = 0;
      if (!m_act) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_act && req[(m_last + k) % N]
              && enable[(m_last + k) % N]) begin
            m_act   = 1;
            e_owner = (m_last + k) % N;
            e_word  = req_word[e_owner];
            e_bytes = req_bytes[e_owner];
            e_ack[e_owner] = 1'b1;
            m_fin  = (e_bytes == 0);
            m_st   = -1;
            m_sent = 0;
            m_flag = 0;
          end
        end
      end else if (m_fin) begin
        e_done[e_owner] = 1'b1;
        e_fault = m_flag;
        m_last = e_owner;
        m_act = 0; m_fin = 0; m_flag = 0;
      end else if (m_st < 0) begin
        m_st = 0;
        e_start = 1;
      end else if (!m_sent) begin
        if (tx_busy) begin
          e_start = 0;
          m_sent = 1;
        end else begin
          m_st++;
          if (m_st == TO) begin
            e_start = 0; m_flag = 1; m_fin = 1;
          end
        end
      end else if (!tx_busy) begin
        m_fin = 1;
      end
      e_busy = m_act;
    end
  end

  always @(negedge clk) begin
    if (rst_n)
      chk("cycle", {ack, done, fault, tx_start, busy, owner,
                    tx_word, tx_bytes},
          {e_ack, e_done, e_fault, e_start, e_busy, 2'(e_owner),
           e_word, e_bytes});
  end

  // Event monitor for the directed literal expectations.
  int cyc = 0;
  int ack_n[N];
  int done_n[N];
  int fault_wd = 0;
  int start_n = 0;
  int grants[$];
  int ack_c[$];
  int done_c[$];

  initial for (int i = 0; i < N; i++) begin
    ack_n[i] = 0; done_n[i] = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          ack_n[i]++; grants.push_back(i); ack_c.push_back(cyc);
        end
        if (done[i]) begin
          done_n[i]++; done_c.push_back(cyc);
        end
      end
      if (fault && done != '0) fault_wd++;
      if (tx_start) start_n++;
    end
  end

  // Downstream sender: raises busy snd_dly cycles into start.
  bit snd_on = 1;
  bit snd_rand = 0;
  int snd_dly = 1;
  int snd_len = 3;
  int s_w = 0;
  int s_h = 0;

  initial begin
    tx_busy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_busy = 0; s_w = 0; s_h = 0;
      end else if (tx_busy) begin
        s_h--;
        if (s_h <= 0) tx_busy = 0;
      end else if (tx_start && snd_on) begin
        if (s_w == 0 && snd_rand) begin
          snd_dly = $urandom_range(1, 20);
          snd_len = $urandom_range(1, 8);
        end
        s_w++;
        if (s_w >= snd_dly) begin
          tx_busy = 1; s_h = snd_len; s_w = 0;
        end
      end else begin
        s_w = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int i, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (ack[i]) ok = 1;
    end
  endtask

  task automatic wait_done(input int i, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (done[i]) ok = 1;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_wait", 0, 1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  int b0, b1, g0, a0, d0, n;
  bit ok;

  initial begin
    req = '0; enable = '1; req_word = '0; req_bytes = '0;
    repeat (3) @(posedge clk);
    step();
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_word", tx_word, 0);
    chk("reset_pulses", {ack, done, fault, tx_start}, 0);
    rst_n = 1;
    step();

    // Single transfer from requester 2.
    snd_dly = 2; snd_len = 40;
    b0 = start_n; a0 = ack_n[2]; d0 = done_n[2];
    req_word[2] = 32'h11223344; req_bytes[2] = 3'd4; req = 4'b0100;
    wait_ack(2, 10, ok);
    chk("s1_ack_seen", ok, 1);
    chk("s1_word", tx_word, 32'h11223344);
    chk("s1_bytes", tx_bytes, 4);
    chk("s1_owner", owner, 2);
    req = '0;
    wait_done(2, 100, ok);
    chk("s1_done_seen", ok, 1);
    chk("s1_word_hold", tx_word, 32'h11223344);
    repeat (3) step();
    chk("s1_ack_cnt", ack_n[2] - a0, 1);
    chk("s1_done_cnt", done_n[2] - d0, 1);
    chk("s1_start_len", start_n - b0, 2);

    // Round robin from reset with all four requesting.
    snd_dly = 1; snd_len = 3;
    for (int i = 0; i < N; i++) req_bytes[i] = 3'(i + 1);
    do_reset();
    g0 = grants.size(); a0 = ack_c.size(); d0 = done_c.size();
    req = 4'b1111;
    for (int c = 0; c < 300 && grants.size() - g0 < 5; c++) step();
    req = '0;
    chk("rr_count", grants.size() - g0, 5);
    for (int k = 0; k < 5; k++)
      if (g0 + k < grants.size())
        chk("rr_order", grants[g0 + k], k % N);
    for (int k = 0; k < 4; k++)
      if (a0 + k + 1 < ack_c.size() && d0 + k < done_c.size())
        chk("rr_gap", ack_c[a0 + k + 1] - done_c[d0 + k], 1);
    wait_idle(100);

    // Zero-byte request: ack then done, no start.
    b0 = start_n;
    req_bytes[1] = 3'd0; req = 4'b0010;
    wait_ack(1, 10, ok);
    chk("zb_ack_seen", ok, 1);
    req = '0;
    step();
    chk("zb_done_next", done, 4'b0010);
    repeat (3) step();
    chk("zb_no_start", start_n - b0, 0);

    // Timeout: sender never answers.
    snd_on = 0;
    b0 = start_n; b1 = fault_wd;
    req_bytes[3] = 3'd5; req = 4'b1000;
    wait_ack(3, 10, ok);
    chk("to_ack_seen", ok, 1);
    req = '0;
    wait_done(3, 60, ok);
    chk("to_done_seen", ok, 1);
    chk("to_fault", fault, 1);
    chk("to_start_len", start_n - b0, TO);
    chk("to_fault_cnt", fault_wd - b1, 1);
    snd_on = 1;
    wait_idle(20);

    // Mask: only requester 0 may win.
    a0 = ack_n[2]; g0 = grants.size();
    enable = 4'b0001; req = 4'b0101;
    req_bytes[0] = 3'd2; req_bytes[2] = 3'd2;
    for (int c = 0; c < 200 && grants.size() - g0 < 3; c++) step();
    req = '0;
    wait_idle(100);
    enable = '1;
    chk("mask_count", grants.size() - g0, 3);
    for (int k = 0; k < 3; k++)
      if (g0 + k < grants.size())
        chk("mask_owner", grants[g0 + k], 0);
    chk("mask_no2", ack_n[2] - a0, 0);

    // Reset while waiting for the sender to finish.
    snd_dly = 1; snd_len = 40;
    req_bytes[3] = 3'd4; req_word[3] = 32'hCAFEF00D; req = 4'b1000;
    wait_ack(3, 10, ok);
    chk("rm_ack_seen", ok, 1);
    req = '0;
    n = 0;
    for (int c = 0; c < 30 && !tx_busy; c++) step();
    repeat (5) step();
    chk("rm_busy_before", {busy, tx_busy}, 2'b11);
    n = 0;
    for (int i = 0; i < N; i++) n += done_n[i];
    rst_n = 0;
    #1;
    chk("rm_outputs", {ack, done, fault, tx_start, busy, owner,
                       tx_word, tx_bytes}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (45) step();
    b0 = 0;
    for (int i = 0; i < N; i++) b0 += done_n[i];
    chk("rm_no_done", b0 - n, 0);

    // Randomized traffic, sender delays straddle the timeout.
    snd_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_word[i] = $urandom;
          req_bytes[i] = 3'($urandom_range(0, 7));
        end else if (req[i] && $urandom_range(0, 63) == 0)
          req[i] = 1'b0;
        else if (!req[i])
          req_word[i] = $urandom;
      end
      if ($urandom_range(0, 31) == 0) enable = 4'($urandom);
    end
    req = '0;
    wait_idle(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
